// File: rtl/ports_io_ctrl.sv
// Avalon-MM LED / GPIO / debounced-key peripheral with maskable key-press interrupt.
// Optional LED PWM dimming is built when PORTS_IO_PWM_EN is defined.
module ports_io_ctrl #(
   parameter int unsigned LED_W           = 8,
   parameter int unsigned GPIO_W          = 8,
   parameter int unsigned KEY_W           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned PWM_W           = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [2:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq,
   output logic [LED_W-1:0]  led_out,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   input  logic [GPIO_W-1:0] gpio_in,
   input  logic [KEY_W-1:0]  key_in
);

   localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

   logic [LED_W-1:0]  r_led;
   logic [GPIO_W-1:0] r_gpio_out;
   logic [GPIO_W-1:0] r_gpio_oe;
   logic [GPIO_W-1:0] r_gpio_s1;
   logic [GPIO_W-1:0] r_gpio_s2;
   logic [KEY_W-1:0]  r_key_s1;
   logic [KEY_W-1:0]  r_key_s2;
   logic [KEY_W-1:0]  r_key_state;
   logic [KEY_W-1:0]  r_key_edge;
   logic [KEY_W-1:0]  r_key_mask;
   logic [31:0]       r_cnt [KEY_W];
   logic [31:0]       r_rdata;

   logic [KEY_W-1:0]  w_pressed;
   logic [KEY_W-1:0]  w_differ;
   logic [KEY_W-1:0]  w_done;
   logic [KEY_W-1:0]  w_set;
   logic [KEY_W-1:0]  w_clr;
   logic [31:0]       w_rdata;
   logic              w_unused;

   // Synchronisers: keys idle high (released), pads idle low
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_key_s1  <= '1;
         r_key_s2  <= '1;
         r_gpio_s1 <= '0;
         r_gpio_s2 <= '0;
      end else begin
         r_key_s1  <= key_in;
         r_key_s2  <= r_key_s1;
         r_gpio_s1 <= gpio_in;
         r_gpio_s2 <= r_gpio_s1;
      end
   end

   always_comb begin
      w_pressed = ~r_key_s2;
      w_differ  = w_pressed ^ r_key_state;
      w_done    = '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
         w_done[i] = w_differ[i] && (r_cnt[i] == DB_LAST);
      end
      w_set = w_done & w_pressed;
      w_clr = (avs_write && (avs_address == 3'd5)) ? avs_writedata[KEY_W-1:0] : '0;
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int unsigned i = 0; i < KEY_W; i++) begin
            r_cnt[i] <= '0;
         end
         r_key_state <= '0;
         r_key_edge  <= '0;
      end else begin
         for (int unsigned i = 0; i < KEY_W; i++) begin
            if (!w_differ[i] || w_done[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 32'd1;
            end
         end
         r_key_state <= (r_key_state & ~w_done) | (w_pressed & w_done);
         // Set is applied after clear so a coincident press survives W1C
         r_key_edge  <= (r_key_edge & ~w_clr) | w_set;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_led      <= '0;
         r_gpio_out <= '0;
         r_gpio_oe  <= '0;
         r_key_mask <= '0;
      end else if (avs_write) begin
         case (avs_address)
            3'd0:    r_led      <= avs_writedata[LED_W-1:0];
            3'd1:    r_gpio_out <= avs_writedata[GPIO_W-1:0];
            3'd2:    r_gpio_oe  <= avs_writedata[GPIO_W-1:0];
            3'd6:    r_key_mask <= avs_writedata[KEY_W-1:0];
            default: ;
         endcase
      end
   end

`ifdef PORTS_IO_PWM_EN
   logic [PWM_W-1:0] r_duty;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic             w_pwm_on;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_duty    <= '1;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
         if (avs_write && (avs_address == 3'd7)) begin
            r_duty <= avs_writedata[PWM_W-1:0];
         end
      end
   end

   // All-ones duty must be fully on, which cnt < duty alone cannot give
   assign w_pwm_on = (r_pwm_cnt < r_duty) || (&r_duty);
   assign led_out  = r_led & {LED_W{w_pwm_on}};
   assign w_unused = ^avs_writedata;
`else
   assign led_out  = r_led;
   assign w_unused = ^{avs_writedata, 32'(PWM_W)};
`endif

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         3'd0: w_rdata = 32'(r_led);
         3'd1: w_rdata = 32'(r_gpio_out);
         3'd2: w_rdata = 32'(r_gpio_oe);
         3'd3: w_rdata = 32'(r_gpio_s2);
         3'd4: w_rdata = 32'(r_key_state);
         3'd5: w_rdata = 32'(r_key_edge);
         3'd6: w_rdata = 32'(r_key_mask);
`ifdef PORTS_IO_PWM_EN
         3'd7: w_rdata = 32'(r_duty);
`else
         3'd7: w_rdata = '0;
`endif
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_rdata <= '0;
      end else if (avs_read) begin
         r_rdata <= w_rdata;
      end
   end

   assign avs_readdata = r_rdata;
   assign irq          = |(r_key_edge & r_key_mask);
   assign gpio_out     = r_gpio_out;
   assign gpio_oe      = r_gpio_oe;

endmodule

// File: tb/tb_ports_io_ctrl.sv
// Self-checking bench for ports_io_ctrl: register vector table plus key debounce,
// interrupt, PWM (when PORTS_IO_PWM_EN is defined) and asynchronous reset sequences.
module tb_ports_io_ctrl;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic [2:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [7:0]  led_out;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic [7:0]  gpio_in = '0;
   logic [1:0]  key_in = 2'b11;

   ports_io_ctrl #(
      .LED_W(8), .GPIO_W(8), .KEY_W(2), .DEBOUNCE_CYCLES(8), .PWM_W(8)
   ) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
      .led_out(led_out), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
      .gpio_in(gpio_in), .key_in(key_in)
   );

   always #5 clk_clk = ~clk_clk;

`ifdef PORTS_IO_PWM_EN
   localparam logic [31:0] RST7 = 32'hFF;
   localparam bit          PWM  = 1'b1;
`else
   localparam logic [31:0] RST7 = 32'h0;
   localparam bit          PWM  = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] sb_exp[$];
   string       sb_name[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk_clk);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk_clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      logic [31:0] e;
      string       n;
      @(negedge clk_clk);
      avs_address = a; avs_read = 1'b1;
      sb_exp.push_back(exp); sb_name.push_back(name);
      @(posedge clk_clk); #1;
      avs_read = 1'b0;
      e = sb_exp.pop_front(); n = sb_name.pop_front();
      chk(n, avs_readdata, e);
   endtask

   task automatic add(input bit wr, input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.exp = e;
      vt.push_back(v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit saw;

      for (int a = 0; a < 7; a++) add(0, 3'(a), '0, '0);
      add(0, 3'd7, '0, RST7);
      add(1, 3'd0, 32'hA5, '0);        add(1, 3'd2, 32'h0F, '0);
      add(1, 3'd1, 32'h3C, '0);        add(0, 3'd0, '0, 32'hA5);
      add(0, 3'd1, '0, 32'h3C);        add(0, 3'd2, '0, 32'h0F);
      add(1, 3'd0, 32'hFFFFFF5A, '0);  add(0, 3'd0, '0, 32'h5A);
      add(1, 3'd0, 32'hA5, '0);        add(0, 3'd0, '0, 32'hA5);
      add(1, 3'd3, 32'hFFFFFFFF, '0);  add(0, 3'd3, '0, 32'h0);
      add(1, 3'd4, 32'hFFFFFFFF, '0);  add(0, 3'd4, '0, 32'h0);
      add(1, 3'd5, 32'h3, '0);         add(0, 3'd5, '0, 32'h0);
      add(1, 3'd6, 32'hFFFFFFFF, '0);  add(0, 3'd6, '0, 32'h3);
      add(1, 3'd6, 32'h0, '0);         add(0, 3'd6, '0, 32'h0);
      add(1, 3'd7, 32'h12345680, '0);  add(0, 3'd7, '0, PWM ? 32'h80 : 32'h0);
      add(1, 3'd7, 32'hFF, '0);        add(0, 3'd7, '0, RST7);

      repeat (3) @(negedge clk_clk);
      reset_reset = 1'b0;
      #1;
      chk("rst_rdata", avs_readdata, '0);
      chk("rst_irq", 32'(irq), '0);
      chk("rst_led", 32'(led_out), '0);
      chk("rst_gpio_out", 32'(gpio_out), '0);
      chk("rst_gpio_oe", 32'(gpio_oe), '0);

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].wr) bus_write(vt[i].addr, vt[i].data);
         else bus_read(vt[i].addr, vt[i].exp, $sformatf("vec%0d_a%0d", i, vt[i].addr));
      end

      chk("led_out", 32'(led_out), 32'hA5);
      chk("gpio_oe", 32'(gpio_oe), 32'h0F);
      chk("gpio_out", 32'(gpio_out), 32'h3C);

      // Pad change lands in GPIO_IN after two edges; a read sampling edge 3 sees it
      @(negedge clk_clk);
      gpio_in = 8'h81;
      avs_address = 3'd3; avs_read = 1'b1;
      @(posedge clk_clk); #1;
      chk("gpio_in_e1", avs_readdata, 32'h0);
      @(posedge clk_clk); #1;
      chk("gpio_in_e2", avs_readdata, 32'h0);
      @(posedge clk_clk); #1;
      chk("gpio_in_e3", avs_readdata, 32'h81);
      avs_read = 1'b0;

      // Bounce shorter than the debounce window must not register
      bus_write(3'd6, 32'h1);
      saw = 1'b0;
      @(negedge clk_clk);
      key_in[0] = 1'b0;
      repeat (5) begin @(negedge clk_clk); saw |= irq; end
      key_in[0] = 1'b1;
      repeat (12) begin @(negedge clk_clk); saw |= irq; end
      chk("bounce_irq", 32'(saw), '0);
      bus_read(3'd4, 32'h0, "bounce_state");
      bus_read(3'd5, 32'h0, "bounce_edge");

      // Held press: KEY_EDGE/irq rise on the 10th edge after the falling input
      @(negedge clk_clk);
      key_in[0] = 1'b0;
      repeat (9) @(posedge clk_clk);
      #1 chk("deb_edge9_irq", 32'(irq), '0);
      @(posedge clk_clk);
      #1 chk("deb_edge10_irq", 32'(irq), 32'h1);
      bus_read(3'd4, 32'h1, "press_state");
      bus_read(3'd5, 32'h1, "press_edge");

      bus_write(3'd6, 32'h0);
      chk("mask0_irq", 32'(irq), '0);
      bus_write(3'd6, 32'h1);
      chk("mask1_irq", 32'(irq), 32'h1);
      bus_write(3'd5, 32'h1);
      chk("w1c_irq", 32'(irq), '0);
      bus_read(3'd5, 32'h0, "w1c_edge");
      bus_read(3'd4, 32'h1, "w1c_state");

      key_in[0] = 1'b1;
      repeat (12) @(negedge clk_clk);
      bus_read(3'd4, 32'h0, "release_state");
      bus_read(3'd5, 32'h0, "release_edge");
      chk("release_irq", 32'(irq), '0);

      // W1C sampled on the same edge key 1's press is accepted: set wins
      @(negedge clk_clk);
      key_in[1] = 1'b0;
      repeat (8) @(negedge clk_clk);
      bus_write(3'd5, 32'h2);
      bus_read(3'd5, 32'h2, "setwins_edge");
      bus_read(3'd4, 32'h2, "setwins_state");
      chk("setwins_irq_masked", 32'(irq), '0);
      bus_write(3'd6, 32'h3);
      chk("setwins_irq", 32'(irq), 32'h1);

`ifdef PORTS_IO_PWM_EN
      bus_write(3'd0, 32'h01);
      bus_write(3'd7, 32'd64);
      cnt = 0;
      repeat (256) begin @(negedge clk_clk); cnt += int'(led_out[0]); end
      chk("pwm_duty64", 32'(cnt), 32'd64);
      bus_write(3'd7, 32'd0);
      cnt = 0;
      repeat (256) begin @(negedge clk_clk); cnt += int'(led_out[0]); end
      chk("pwm_duty0", 32'(cnt), 32'd0);
      bus_write(3'd7, 32'd255);
      cnt = 0;
      repeat (256) begin @(negedge clk_clk); cnt += int'(led_out[0]); end
      chk("pwm_duty255", 32'(cnt), 32'd256);
`endif

      // Reset mid-debounce with an edge pending
      @(negedge clk_clk);
      key_in[0] = 1'b0;
      repeat (5) @(posedge clk_clk);
      #2 reset_reset = 1'b1;
      #1;
      chk("amid_irq", 32'(irq), '0);
      chk("amid_led", 32'(led_out), '0);
      chk("amid_gpio_oe", 32'(gpio_oe), '0);
      chk("amid_gpio_out", 32'(gpio_out), '0);
      chk("amid_rdata", avs_readdata, '0);
      @(negedge clk_clk);
      reset_reset = 1'b0;
      avs_address = 3'd6; avs_writedata = 32'h1; avs_write = 1'b1;
      @(posedge clk_clk); #1;
      avs_write = 1'b0;
      repeat (8) @(posedge clk_clk);
      #1 chk("post_rst_edge9_irq", 32'(irq), '0);
      @(posedge clk_clk);
      #1 chk("post_rst_edge10_irq", 32'(irq), 32'h1);
      bus_read(3'd0, 32'h0, "post_rst_led");
      bus_read(3'd1, 32'h0, "post_rst_out");
      bus_read(3'd2, 32'h0, "post_rst_oe");
      bus_read(3'd4, 32'h3, "post_rst_state");
      bus_read(3'd5, 32'h3, "post_rst_edge");
      bus_read(3'd6, 32'h1, "post_rst_mask");
      bus_read(3'd7, RST7, "post_rst_duty");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
